// File: rtl/aes_key_schedule.sv
// aes_key_schedule: runtime-selectable AES-128/192/256 key expansion.
// One 32-bit schedule word is produced per cycle into an internal word RAM.
// Round keys are read back through a registered, addressed port.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             request expansion (honoured only in IDLE / READY)
//   key_len           00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_in            cipher key, word 0 in the MSBs
//   busy              high while loading or expanding
//   done              one-cycle pulse after the last word is written
//   err               one-cycle pulse when a start is rejected
//   rk_ready          a complete schedule is held
//   rk_addr / rk_out  round index in, 128-bit round key out (latency 1)

// Single-byte AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  always_comb begin
    logic [7:0] p;
    // x^254 = prod of x^(2^k), k=1..7; maps 0 to 0 as AES requires
    inv = 8'h01;
    p   = a;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_schedule #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rk_ready,
  input  logic [3:0]            rk_addr,
  output logic [127:0]          rk_out
);
  localparam int DEPTH = 4*(MAX_NK+7);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_READY} state_t;

  state_t               state_q, state_d;
  logic [32*MAX_NK-1:0] key_q, key_d;
  logic [1:0]           klen_q, klen_d;
  logic [5:0]           i_q, i_d;      // DEPTH never exceeds 60 words
  logic [2:0]           j_q, j_d;      // i mod Nk without a divider
  logic [7:0]           rcon_q, rcon_d;
  logic [31:0]          prev_q, prev_d; // w[i-1], avoids a second RAM read
  logic                 done_q, done_d, err_q, err_d, rdy_q, rdy_d;
  logic [127:0]         rk_out_q, rk_out_d;

  logic [31:0] ram [DEPTH];
  logic        ram_we;
  logic [5:0]  ram_wa;
  logic [31:0] ram_wd;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      2'b10:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  logic [3:0]  nk, nr, start_nk;
  logic        start_ok;
  logic [5:0]  last_i, base;
  logic [31:0] key_word, sb_in, sb_out, f, exp_word;

  assign nk       = nk_of(klen_q);
  assign nr       = nk + 4'd6;
  assign last_i   = {nk, 2'b00} + 6'd27;   // 4*(Nr+1)-1
  assign start_nk = nk_of(key_len);
  assign start_ok = (key_len != 2'b11) && (start_nk <= MAX_NK_W);
  assign base     = {rk_addr, 2'b00};

  always_comb begin
    key_word = '0;
    for (int w = 0; w < MAX_NK; w++)
      if (6'(w) == i_q) key_word = key_q[32*(MAX_NK-1-w) +: 32];
  end

  // RotWord only at the start of each Nk group
  assign sb_in = (j_q == 3'd0) ? {prev_q[23:0], prev_q[31:24]} : prev_q;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .s(sb_out[8*b +: 8]));
  end

  always_comb begin
    f = prev_q;
    if (j_q == 3'd0)                      f = sb_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && j_q == 3'd4)   f = sb_out;
    exp_word = ram[i_q - {2'b00, nk}] ^ f;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    klen_d  = klen_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    prev_d  = prev_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdy_d   = rdy_q;
    ram_we  = 1'b0;
    ram_wa  = i_q;
    ram_wd  = key_word;
    case (state_q)
      S_IDLE, S_READY: begin
        if (start) begin
          if (start_ok) begin
            state_d = S_LOAD;
            key_d   = key_in;
            klen_d  = key_len;
            rdy_d   = 1'b0;
            i_d     = 6'd0;
            j_d     = 3'd0;
            rcon_d  = 8'h01;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        ram_we = 1'b1;
        prev_d = key_word;
        i_d    = i_q + 6'd1;
        if (i_q == {2'b00, nk} - 6'd1) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        ram_we = 1'b1;
        ram_wd = exp_word;
        prev_d = exp_word;
        i_d    = i_q + 6'd1;
        j_d    = ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (i_q == last_i) begin
          state_d = S_READY;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rk_out_d = '0;
    if (rdy_q && rk_addr <= nr)
      rk_out_d = {ram[base], ram[base + 6'd1], ram[base + 6'd2], ram[base + 6'd3]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      klen_q   <= 2'b00;
      i_q      <= 6'd0;
      j_q      <= 3'd0;
      rcon_q   <= 8'h01;
      prev_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      klen_q   <= klen_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      prev_q   <= prev_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      rk_out_q <= rk_out_d;
    end
  end

  // Storage is not reset; rk_ready low marks its contents invalid.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[ram_wa] <= ram_wd;
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_EXPAND);
  assign done     = done_q;
  assign err      = err_q;
  assign rk_ready = rdy_q;
  assign rk_out   = rk_out_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 vectors for all key sizes,
// latency/busy length, reject paths, mid-run disturbance, reset and restart.
module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         reset, start, start4;
  logic [1:0]   key_len, key_len4;
  logic [255:0] key_in;
  logic [127:0] key_in4;
  logic [3:0]   rk_addr, rk_addr4;
  logic         busy, done, err, rk_ready;
  logic         busy4, done4, err4, rk_ready4;
  logic [127:0] rk_out, rk_out4;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule #(.MAX_NK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .rk_ready(rk_ready),
    .rk_addr(rk_addr), .rk_out(rk_out)
  );

  aes_key_schedule #(.MAX_NK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .key_len(key_len4), .key_in(key_in4),
    .busy(busy4), .done(done4), .err(err4), .rk_ready(rk_ready4),
    .rk_addr(rk_addr4), .rk_out(rk_out4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] v);
    rk_addr = a;
    tick();
    v = rk_out;
  endtask

  // Start an expansion and run to done (bounded). Optionally fires extra
  // starts mid-EXPAND; key inputs are scrambled right after the start cycle.
  task automatic run(input logic [1:0] kl, input logic [255:0] k, input bit disturb,
                     output int lat, output int bc, output int errs,
                     output logic rdy1, output logic [127:0] mid_out);
    key_len = kl;
    key_in  = k;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    key_in  = ~k;
    key_len = 2'b11;
    rdy1    = rk_ready;
    bc      = busy ? 1 : 0;
    lat     = 0;
    errs    = 0;
    mid_out = 'x;
    while (!done && lat < 200) begin
      if (disturb && (lat == 15 || lat == 25)) begin
        start   = 1'b1;
        key_len = (lat == 15) ? 2'b11 : 2'b10;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (busy) bc++;
      if (err)  errs++;
      if (lat == 5) mid_out = rk_out;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bc, errs;
    logic rdy1;
    logic [127:0] mid, v;

    reset = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0; rk_addr = 4'd0;
    start4 = 1'b0; key_len4 = 2'b00; key_in4 = '0; rk_addr4 = 4'd0;
    tick(); tick();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_rdy", 128'(rk_ready), 128'd0);
    chk("rst_rkout", rk_out, 128'd0);
    reset = 1'b0;
    tick();

    // illegal key_len in IDLE
    key_len = 2'b11; start = 1'b1;
    key_len4 = 2'b10; start4 = 1'b1;   // AES-256 on a MAX_NK=4 instance
    tick();
    start = 1'b0; start4 = 1'b0;
    chk("ill_err", 128'(err), 128'd1);
    chk("ill_busy", 128'(busy), 128'd0);
    chk("ill_rdy", 128'(rk_ready), 128'd0);
    chk("nk4_err", 128'(err4), 128'd1);
    chk("nk4_busy", 128'(busy4), 128'd0);
    tick();
    chk("ill_err_pulse", 128'(err), 128'd0);
    chk("ill_busy2", 128'(busy), 128'd0);

    // AES-128 with disturbance mid-EXPAND
    rk_addr = 4'd0;
    run(2'b00, K128, 1'b1, lat, bc, errs, rdy1, mid);
    chk("a128_lat", 128'(lat), 128'd44);
    chk("a128_busy_cycles", 128'(bc), 128'd44);
    chk("a128_no_err", 128'(errs), 128'd0);
    chk("a128_rdy", 128'(rk_ready), 128'd1);
    tick();
    chk("a128_done_pulse", 128'(done), 128'd0);
    rd(4'd0, v);  chk("a128_rk0", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(4'd1, v);  chk("a128_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, v); chk("a128_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd11, v); chk("a128_rk11", v, 128'd0);

    // AES-192 restart from READY
    run(2'b01, K192, 1'b0, lat, bc, errs, rdy1, mid);
    chk("a192_lat", 128'(lat), 128'd52);
    chk("a192_busy_cycles", 128'(bc), 128'd52);
    rd(4'd0, v);  chk("a192_rk0", v, 128'h8e73b0f7da0e6452c810f32b809079e5);
    rd(4'd12, v); chk("a192_rk12", v, 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd13, v); chk("a192_rk13", v, 128'd0);

    // illegal start while READY keeps the schedule
    key_len = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rdy_ill_err", 128'(err), 128'd1);
    chk("rdy_ill_rdy", 128'(rk_ready), 128'd1);
    rd(4'd12, v); chk("rdy_ill_rk12", v, 128'he98ba06f448c773c8ecc720401002202);

    // AES-256
    run(2'b10, K256, 1'b0, lat, bc, errs, rdy1, mid);
    chk("a256_lat", 128'(lat), 128'd60);
    chk("a256_busy_cycles", 128'(bc), 128'd60);
    rd(4'd0, v);  chk("a256_rk0", v, 128'h603deb1015ca71be2b73aef0857d7781);
    rd(4'd1, v);  chk("a256_rk1", v, 128'h1f352c073b6108d72d9810a30914dff4);
    rd(4'd14, v); chk("a256_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);
    rd(4'd15, v); chk("a256_rk15", v, 128'd0);

    // AES-128 restart from READY after AES-256
    rk_addr = 4'd0;
    run(2'b00, K128, 1'b0, lat, bc, errs, rdy1, mid);
    chk("rs_rdy_drop", 128'(rdy1), 128'd0);
    chk("rs_rk0_busy", mid, 128'd0);
    chk("rs_lat", 128'(lat), 128'd44);
    rd(4'd1, v);  chk("rs_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, v); chk("rs_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // reset mid-EXPAND
    rk_addr = 4'd0;
    key_len = 2'b00; key_in = K128; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("mid_busy_pre", 128'(busy), 128'd1);
    reset = 1'b1;
    tick();
    chk("mr_busy", 128'(busy), 128'd0);
    chk("mr_rdy", 128'(rk_ready), 128'd0);
    chk("mr_rkout", rk_out, 128'd0);
    reset = 1'b0;
    tick();
    run(2'b00, K128, 1'b0, lat, bc, errs, rdy1, mid);
    chk("mr_lat", 128'(lat), 128'd44);
    rd(4'd1, v);  chk("mr_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, v); chk("mr_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Runtime-selectable AES key expansion engine covering AES-128, AES-192 and AES-256 (FIPS-197).
- Computes one 32-bit schedule word per cycle into an internal word RAM.
- Exposes round keys through an addressed, registered read port instead of a flattened all-keys bus.
- Sits between the key register file and the cipher/decipher round datapaths, which read keys by round index once rk_ready is high.

Parameters:
MAX_NK, 8, largest key length supported in 32-bit words (4, 6 or 8); storage is 4*(MAX_NK+7) words; key lengths above MAX_NK are rejected.

Ports:
clk  input  1  clock, all logic rising-edge.
reset  input  1  synchronous, active-high.
start  input  1  request expansion; sampled only in IDLE or READY.
key_len  input  2  00=AES-128 (Nk=4, Nr=10), 01=AES-192 (Nk=6, Nr=12), 10=AES-256 (Nk=8, Nr=14), 11=illegal.
key_in  input  32*MAX_NK  cipher key, word 0 in the MSBs; only the top 32*Nk bits are used.
busy  output  1  high in LOAD and EXPAND.
done  output  1  one-cycle pulse when the last word has been written.
err  output  1  one-cycle pulse when start is rejected.
rk_ready  output  1  level; high while a complete schedule is held.
rk_addr  input  4  round index 0..Nr.
rk_out  output  128  round key for rk_addr = words 4r..4r+3, word 4r in the MSBs; registered, latency 1.

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, rk_ready=0, rk_out=0; word counter i=0, rcon=01. RAM contents need not be cleared; rk_ready=0 invalidates them. Reset wins over every other input in the same cycle.
- States and transitions:
  - IDLE/READY + start with legal key_len (Nk<=MAX_NK) -> LOAD. In the same cycle: capture key_in and key_len into internal registers, clear rk_ready, set i=0, rcon=01, j=0.
  - IDLE/READY + start with illegal key_len (11, or Nk>MAX_NK) -> stay in the current state. err pulses next cycle; rk_ready unchanged.
  - LOAD: write captured key word i to RAM[i], one per cycle. After word Nk-1 is written -> EXPAND with i=Nk.
  - EXPAND: write RAM[i] = RAM[i-Nk] ^ f, where:
    - j==0: f = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then advance rcon by GF(2^8) xtime (..80 -> 1b -> 36).
    - Nk==8 and j==4: f = SubWord(w[i-1]).
    - otherwise: f = w[i-1].
    - w[i-1] comes from a holding register of the last written word, not a RAM read.
  - j is a mod-Nk counter replacing i mod Nk; no divider is allowed.
  - Last word i = 4*(Nr+1)-1 written -> READY. done and rk_ready rise the next cycle.
- Latency: start accepted at cycle 0 -> done at cycle 4*(Nr+1): 44, 52 and 60 cycles for AES-128, -192 and -256.
- busy is high for exactly 4*(Nr+1) cycles.
- start while busy: ignored, no err, the running expansion is unaffected.
- key_in and key_len may change freely after the start cycle.
- Read port:
  - rk_out updates every cycle from rk_addr, in any state.
  - Returns 0 when rk_ready=0 or rk_addr>Nr of the held schedule.
- SubWord uses the team's existing 32-bit S-box substitution block. The combinational path is: RAM/holding register -> S-box -> XOR -> RAM write, in one cycle.
- Restart from READY discards the old schedule; rk_ready drops the cycle after start.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> done 44 cycles later; rk_addr=1 gives a0fafe1788542cb123a339392a6c7605; rk_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at 52 cycles; rk_addr=12 gives e98ba06f448c773c8ecc720401002202; rk_addr=13 gives 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at 60 cycles; rk_addr=14 gives fe4890d1e6188d0b046df344706c631e (exercises the j==4 SubWord path).
- key_len=11 start in IDLE -> err pulse, busy stays 0, rk_ready stays 0. Repeat with MAX_NK=4 and key_len=10 -> err pulse. Extra start pulses and key_in changes mid-EXPAND -> no effect, AES-128 result unchanged.
- Reset asserted mid-EXPAND (cycle 20) -> next cycle busy=0, rk_ready=0, rk_out=0. A new AES-128 start then completes in 44 cycles with correct keys.
- AES-256 complete, then AES-128 restart from READY -> rk_ready drops next cycle, rk_addr=0 reads 0 during busy, final keys match the AES-128 vector.
